// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_tx and uart_rx: frame geometry, FSM state
// type and the baud divisor helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_done on the last cycle of each bit. clear restarts the period.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic bit_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_done = en & ~clear & (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte input, registered serial output,
// start bit, 8 data bits LSB first, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 12_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       uarttx,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [2:0]  LAST_BIT     = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_divisor
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  uart_state_t state, state_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic        tx_nxt, ready_nxt, busy_nxt;
  logic        armed;
  logic        accept;
  logic        bit_done;

  // armed stays low for the first edge after reset release, so a request
  // already present at release is only taken on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  assign accept = valid_in & ready_out & armed;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (accept),
    .en      (state != IDLE),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      uarttx    <= 1'b1;
      ready_out <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift     <= shift_nxt;
      bit_idx   <= bit_idx_nxt;
      uarttx    <= tx_nxt;
      ready_out <= ready_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_idx_nxt = bit_idx;
    tx_nxt      = 1'b1;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = START;
          shift_nxt   = data_in;
          bit_idx_nxt = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_nxt = shift >> 1;
          if (bit_idx == LAST_BIT) state_nxt = STOP;
          else                     bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    ready_nxt = (state_nxt == IDLE);
    busy_nxt  = !ready_nxt;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised self-checking bench for uart_tx at CLKS_PER_BIT=16, using a
// frame-position model plus a line decoder sampling bit centres.
module tb_uart_tx;

  localparam int CPB = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       uarttx;
  logic       busy;

  uart_tx #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .uarttx   (uarttx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endtask

  // Model: m_k is the position within the frame (0 = idle, 1..FRAME = frame cycle).
  int         m_k = 0;
  bit         m_armed = 0;
  logic [7:0] m_byte = '0;
  int         m_acc = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_k = 0;
      m_armed = 0;
      exp_q.delete();
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (m_k == 0) begin
      if (valid_in) begin
        m_k = 1;
        m_byte = data_in;
        m_acc++;
        exp_q.push_back(data_in);
      end
    end else if (m_k == FRAME) begin
      m_k = 0;
    end else begin
      m_k++;
    end
  end

  function automatic logic exp_line(input int k, input logic [7:0] b);
    int slot;
    if (k == 0) return 1'b1;
    slot = (k - 1) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    chk("uarttx", uarttx, exp_line(m_k, m_byte));
    chk("ready_out", ready_out, m_k == 0);
    chk("busy", busy, m_k != 0);
  end

  // Line decoder: samples at bit centres, independent of the model's state.
  bit         in_frame = 0;
  int         fs = 0, prev_fs = 0, rise_off = -1, last_rise = -1;
  logic [9:0] mb = '0, last_bits = '0;
  logic [7:0] last_byte = '0;
  int         n_frames = 0;
  int         busy_run = 0, last_busy = 0;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run = 0;
    end
    if (!reset) begin
      in_frame = 0;
    end else if (!in_frame) begin
      if (uarttx == 1'b0) begin
        in_frame = 1;
        prev_fs = fs;
        fs = cyc;
        rise_off = -1;
      end
    end else begin
      int off;
      off = cyc - fs;
      if (uarttx && rise_off < 0) rise_off = off;
      if (off % CPB == CPB / 2) mb[off / CPB] = uarttx;
      if (off == 9 * CPB + CPB / 2) begin
        in_frame = 0;
        last_bits = mb;
        last_byte = mb[8:1];
        last_rise = rise_off;
        n_frames++;
        chk("start_bit", mb[0], 1'b0);
        chk("stop_bit", mb[9], 1'b1);
        chk("rx_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          chk("rx_byte", mb[8:1], exp_b);
        end
      end
    end
  end

  int n_sent = 0;

  task automatic send(input logic [7:0] b, input bit drop);
    bit ok;
    ok = 0;
    @(negedge clk);
    data_in = b;
    valid_in = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (ready_out) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("send_accept", ok, 1'b1);
    n_sent++;
    if (drop) begin
      @(negedge clk);
      valid_in = 1'b0;
      data_in = 8'($urandom);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    valid_in = 1'b0;
    data_in = 8'h00;

    // 1: reset then idle
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("idle_frames", n_frames, 0);
    chk("idle_accepts", m_acc, 0);

    // 2: 8'hA5
    send(8'hA5, 1);
    repeat (FRAME + 10) @(negedge clk);
    chk("a5_samples", last_bits, 10'b1101001010);
    chk("a5_byte", last_byte, 8'hA5);
    chk("a5_edge_to_edge", last_rise, CPB);
    chk("a5_busy_len", last_busy, FRAME);

    // 3: back-to-back with valid held
    send(8'h00, 0);
    send(8'hFF, 1);
    repeat (FRAME + 10) @(negedge clk);
    chk("b2b_period", fs - prev_fs, FRAME + 1);
    chk("b2b_last_byte", last_byte, 8'hFF);

    // 4: input noise during a frame
    send(8'h3C, 1);
    repeat (150) begin
      @(negedge clk);
      valid_in = 1'($urandom);
      data_in = 8'($urandom);
    end
    valid_in = 1'b0;
    repeat (30) @(negedge clk);
    chk("noise_byte", last_byte, 8'h3C);
    chk("noise_accepts", m_acc, n_sent);

    // 5: reset mid-frame, request pending across release
    send(8'h5A, 1);
    repeat (49) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_tx", uarttx, 1'b1);
    chk("async_rst_ready", ready_out, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    data_in = 8'h81;
    valid_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    n_sent++;
    repeat (FRAME + 10) @(negedge clk);
    chk("post_rst_byte", last_byte, 8'h81);

    // random traffic
    for (int n = 0; n < 25; n++) begin
      bit drop;
      drop = ($urandom_range(0, 3) != 0);
      send(8'($urandom_range(0, 255)), drop);
      if (drop) repeat ($urandom_range(0, 200)) @(negedge clk);
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (FRAME + 20) @(negedge clk);
    chk("final_accepts", m_acc, n_sent);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
